rsnn_lif_array: RTL and testbench

Parametrised recurrent spiking core, the next generation of the fixed 3-in/3-neuron RSNN top.
- N_NEU leaky integrate-and-fire neurons, each with signed weights from N_IN external inputs plus all N_NEU recurrent outputs.
- Per-network threshold, leak and refractory period, all loaded through the serial parameter stream.
- One time step is time-multiplexed over a single shared accumulator.
- Sits directly under the TinyTapeout wrapper; pins map 1:1 to the ports below.

---
 rtl/rsnn_pkg.sv | 40 ++++
 rtl/rsnn_cfg_loader.sv | 82 ++++++++
 rtl/rsnn_lif_array.sv | 217 +++++++++++++++++++++
 tb/tb_rsnn_lif_array.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsnn_pkg.sv
// rtl/rsnn_pkg.sv - shared types and config-layout helpers for the recurrent LIF core
//
// Purpose: FSM state encoding, total config length and the LSB position of
// every config field. Fields are packed MSB-first in this order:
// w[0][0], w[0][1], ... w[N_NEU-1][N_IN+N_NEU-1], threshold, leak, refr.
// Ports: none (package).

package rsnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int cfg_bits(input int n_in, input int n_neu, input int w_bits,
                                  input int v_bits, input int r_bits);
    return n_neu * (n_in + n_neu) * w_bits + 2 * v_bits + r_bits;
  endfunction

  // Weight j,k sits at flat slot j*(n_in+n_neu)+k counted down from the MSB.
  function automatic int weight_lsb(input int j, input int k, input int n_in, input int n_neu,
                                    input int w_bits, input int total_bits);
    return total_bits - (j * (n_in + n_neu) + k + 1) * w_bits;
  endfunction

  function automatic int thr_lsb(input int v_bits, input int r_bits);
    return v_bits + r_bits;
  endfunction

  function automatic int leak_lsb(input int r_bits);
    return r_bits;
  endfunction

  function automatic int refr_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/rsnn_cfg_loader.sv
// rtl/rsnn_cfg_loader.sv - serial configuration shift register and load tracking
//
// Purpose: shifts data_in in MSB-first while load_params is high, counts bits,
// pulses end_writing on the final bit and keeps data_written while a complete
// configuration is held. Loading is frozen while the core is busy.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           global clock enable (state holds, pulses suppressed when 0)
//   load_params   shift enable
//   data_in       serial config bit
//   busy          core time step in progress; blocks shifting
//   cfg           parallel configuration word
//   end_writing   one-cycle pulse after the last config bit
//   data_written  sticky flag: full valid config held

module rsnn_cfg_loader
  import rsnn_pkg::*;
#(
  parameter int CFG_BITS = 56
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                load_params,
  input  logic                data_in,
  input  logic                busy,
  output logic [CFG_BITS-1:0] cfg,
  output logic                end_writing,
  output logic                data_written
);

  localparam int CNT_W = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dw_q, dw_d;
  logic                ew_q, ew_d;

  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    dw_d  = dw_q;
    ew_d  = 1'b0;
    if (load_params && !busy) begin
      cfg_d = {cfg_q[CFG_BITS-2:0], data_in};
      // A new load invalidates the old config as soon as its first bit lands.
      if (cnt_q == '0) dw_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        dw_d  = 1'b1;
        ew_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!load_params) begin
      // Dropping load_params early abandons a partial load.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
      cnt_q <= '0;
      dw_q  <= 1'b0;
      ew_q  <= 1'b0;
    end else if (ena) begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      dw_q  <= dw_d;
      ew_q  <= ew_d;
    end else begin
      ew_q  <= 1'b0;
    end
  end

  assign cfg          = cfg_q;
  assign end_writing  = ew_q;
  assign data_written = dw_q;

endmodule

// File: rtl/rsnn_lif_array.sv
// rtl/rsnn_lif_array.sv - time-multiplexed recurrent leaky integrate-and-fire array
//
// Purpose: N_NEU LIF neurons sharing one accumulator. A time step walks every
// neuron through N_IN+N_NEU accumulate cycles and one update cycle, then
// publishes all new spikes at once.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           global clock enable
//   load_params   serial config shift enable
//   data_in       serial config bit, MSB-first
//   spike_in      external spikes, latched when a step is accepted
//   step          request one time step
//   busy          time step in progress
//   out_spikes    neuron spikes from the last completed step
//   step_done     one-cycle pulse when out_spikes update
//   end_writing   one-cycle pulse on the last config bit
//   data_written  full valid config held

module rsnn_lif_array
  import rsnn_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_NEU  = 3,
  parameter int W_BITS = 2,
  parameter int V_BITS = 8,
  parameter int R_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load_params,
  input  logic             data_in,
  input  logic [N_IN-1:0]  spike_in,
  input  logic             step,
  output logic             busy,
  output logic [N_NEU-1:0] out_spikes,
  output logic             step_done,
  output logic             end_writing,
  output logic             data_written
);

  localparam int NSRC     = N_IN + N_NEU;
  localparam int CFG_BITS = cfg_bits(N_IN, N_NEU, W_BITS, V_BITS, R_BITS);
  localparam int NEU_W    = (N_NEU > 1) ? $clog2(N_NEU) : 1;
  localparam int SRC_W    = $clog2(NSRC);
  localparam int ACC_BITS = V_BITS + 3;
  localparam int THR_LSB  = thr_lsb(V_BITS, R_BITS);
  localparam int LEAK_LSB = leak_lsb(R_BITS);
  localparam int REFR_LSB = refr_lsb();
  localparam logic [NEU_W-1:0] NEU_LAST = NEU_W'(N_NEU - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NSRC - 1);

  logic [CFG_BITS-1:0] cfg;
  logic [W_BITS-1:0]   w_arr [N_NEU][NSRC];
  logic [V_BITS-1:0]   thr, leak;
  logic [R_BITS-1:0]   refr_cfg;

  state_e                     state_q, state_d;
  logic [NEU_W-1:0]           neu_q, neu_d;
  logic [SRC_W-1:0]           src_q, src_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [N_IN-1:0]            spk_q, spk_d;
  logic [N_NEU-1:0]           nxt_q, nxt_d;
  logic [N_NEU-1:0]           out_q, out_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [V_BITS-1:0]          v_q [N_NEU];
  logic [V_BITS-1:0]          v_d [N_NEU];
  logic [R_BITS-1:0]          refr_q [N_NEU];
  logic [R_BITS-1:0]          refr_d [N_NEU];

  logic [NSRC-1:0]            src_bits;
  logic [W_BITS-1:0]          w_cur;
  logic signed [ACC_BITS-1:0] v_sum;
  logic [V_BITS-1:0]          v_clamp;

  rsnn_cfg_loader #(.CFG_BITS(CFG_BITS)) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .load_params  (load_params),
    .data_in      (data_in),
    .busy         (busy_q),
    .cfg          (cfg),
    .end_writing  (end_writing),
    .data_written (data_written)
  );

  for (genvar j = 0; j < N_NEU; j++) begin : g_wj
    for (genvar k = 0; k < NSRC; k++) begin : g_wk
      localparam int LSB = weight_lsb(j, k, N_IN, N_NEU, W_BITS, CFG_BITS);
      assign w_arr[j][k] = cfg[LSB +: W_BITS];
    end
  end

  assign thr      = cfg[THR_LSB +: V_BITS];
  assign leak     = cfg[LEAK_LSB +: V_BITS];
  assign refr_cfg = cfg[REFR_LSB +: R_BITS];

  // Recurrent sources read the spikes published by the previous step, which
  // stay stable until DONE.
  assign src_bits = {out_q, spk_q};
  assign w_cur    = w_arr[neu_q][src_q];

  always_comb begin
    v_sum = $signed({3'b000, v_q[neu_q]}) + acc_q - $signed({3'b000, leak});
    if (v_sum[ACC_BITS-1]) begin
      v_clamp = '0;
    end else if (v_sum > $signed({3'b000, {V_BITS{1'b1}}})) begin
      v_clamp = '1;
    end else begin
      v_clamp = v_sum[V_BITS-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    neu_d   = neu_q;
    src_d   = src_q;
    acc_d   = acc_q;
    spk_d   = spk_q;
    nxt_d   = nxt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    v_d     = v_q;
    refr_d  = refr_q;
    case (state_q)
      ST_IDLE: begin
        if (step && data_written && !load_params) begin
          state_d = ST_ACCUM;
          neu_d   = '0;
          src_d   = '0;
          acc_d   = '0;
          spk_d   = spike_in;
          busy_d  = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (src_bits[src_q]) begin
          acc_d = acc_q + {{(ACC_BITS - W_BITS){w_cur[W_BITS-1]}}, w_cur};
        end
        if (src_q == SRC_LAST) begin
          state_d = ST_UPDATE;
        end else begin
          src_d = src_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        if (refr_q[neu_q] != '0) begin
          refr_d[neu_q] = refr_q[neu_q] - 1'b1;
          v_d[neu_q]    = '0;
          nxt_d[neu_q]  = 1'b0;
        end else if (v_clamp >= thr) begin
          refr_d[neu_q] = refr_cfg;
          v_d[neu_q]    = '0;
          nxt_d[neu_q]  = 1'b1;
        end else begin
          v_d[neu_q]    = v_clamp;
          nxt_d[neu_q]  = 1'b0;
        end
        if (neu_q == NEU_LAST) begin
          state_d = ST_DONE;
        end else begin
          neu_d   = neu_q + 1'b1;
          src_d   = '0;
          acc_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        out_d   = nxt_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      neu_q   <= '0;
      src_q   <= '0;
      acc_q   <= '0;
      spk_q   <= '0;
      nxt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_NEU; i++) begin
        v_q[i]    <= '0;
        refr_q[i] <= '0;
      end
    end else if (ena) begin
      state_q <= state_d;
      neu_q   <= neu_d;
      src_q   <= src_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
      nxt_q   <= nxt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v_q     <= v_d;
      refr_q  <= refr_d;
    end else begin
      done_q  <= 1'b0;
    end
  end

  assign busy       = busy_q;
  assign out_spikes = out_q;
  assign step_done  = done_q;

endmodule

// File: tb/tb_rsnn_lif_array.sv
// tb/tb_rsnn_lif_array.sv - self-checking bench for rsnn_lif_array

module tb_rsnn_lif_array;

  localparam int N_IN   = 3;
  localparam int N_NEU  = 3;
  localparam int W_BITS = 2;
  localparam int V_BITS = 8;
  localparam int R_BITS = 4;
  localparam int NSRC   = N_IN + N_NEU;
  localparam int CFG    = N_NEU * NSRC * W_BITS + 2 * V_BITS + R_BITS;
  localparam int LAT    = N_NEU * (NSRC + 1) + 1;

  logic             clk = 1'b0;
  logic             rst_n, ena, load_params, data_in, step;
  logic [N_IN-1:0]  spike_in;
  logic             busy, step_done, end_writing, data_written;
  logic [N_NEU-1:0] out_spikes;

  int n_cmp = 0;
  int n_bad = 0;

  int               mw [N_NEU][NSRC];
  int               mthr, mleak, mrefr;
  int               mv [N_NEU];
  int               mrc [N_NEU];
  logic [N_NEU-1:0] mout;

  rsnn_lif_array #(.N_IN(N_IN), .N_NEU(N_NEU), .W_BITS(W_BITS), .V_BITS(V_BITS),
                   .R_BITS(R_BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .load_params  (load_params),
    .data_in      (data_in),
    .spike_in     (spike_in),
    .step         (step),
    .busy         (busy),
    .out_spikes   (out_spikes),
    .step_done    (step_done),
    .end_writing  (end_writing),
    .data_written (data_written)
  );

  always #5 clk = ~clk;

  function automatic void model_clear_cfg();
    for (int j = 0; j < N_NEU; j++)
      for (int k = 0; k < NSRC; k++) mw[j][k] = 0;
    mthr = 0; mleak = 0; mrefr = 0;
  endfunction

  function automatic void model_random_cfg();
    for (int j = 0; j < N_NEU; j++)
      for (int k = 0; k < NSRC; k++) mw[j][k] = int'($urandom_range(0, 3)) - 2;
    mthr  = int'($urandom_range(0, 5));
    mleak = int'($urandom_range(0, 2));
    mrefr = int'($urandom_range(0, 3));
  endfunction

  function automatic logic [CFG-1:0] pack_cfg();
    logic [CFG-1:0] c;
    logic [31:0]    t;
    int             pos;
    c   = '0;
    pos = CFG;
    for (int j = 0; j < N_NEU; j++)
      for (int k = 0; k < NSRC; k++) begin
        t = mw[j][k];
        for (int b = W_BITS - 1; b >= 0; b--) begin pos--; c[pos] = t[b]; end
      end
    t = mthr;
    for (int b = V_BITS - 1; b >= 0; b--) begin pos--; c[pos] = t[b]; end
    t = mleak;
    for (int b = V_BITS - 1; b >= 0; b--) begin pos--; c[pos] = t[b]; end
    t = mrefr;
    for (int b = R_BITS - 1; b >= 0; b--) begin pos--; c[pos] = t[b]; end
    return c;
  endfunction

  // One network time step computed directly from the neuron equations.
  function automatic void model_step(input logic [N_IN-1:0] s);
    logic [N_NEU-1:0] ns;
    int acc, vp;
    ns = '0;
    for (int j = 0; j < N_NEU; j++) begin
      acc = 0;
      for (int k = 0; k < N_IN; k++)  if (s[k]) acc += mw[j][k];
      for (int r = 0; r < N_NEU; r++) if (mout[r]) acc += mw[j][N_IN + r];
      if (mrc[j] > 0) begin
        mrc[j]--; mv[j] = 0;
      end else begin
        vp = mv[j] + acc - mleak;
        if (vp < 0) vp = 0;
        if (vp > (1 << V_BITS) - 1) vp = (1 << V_BITS) - 1;
        if (vp >= mthr) begin ns[j] = 1'b1; mv[j] = 0; mrc[j] = mrefr; end
        else mv[j] = vp;
      end
    end
    mout = ns;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; ena = 1'b1; load_params = 1'b0; data_in = 1'b0; step = 1'b0; spike_in = '0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < N_NEU; j++) begin mv[j] = 0; mrc[j] = 0; end
    mout = '0;
  endtask

  task automatic shift_bits(input logic [CFG-1:0] c, input int nbits, input logic with_step,
                            output int ew_pos, output int ew_cnt, output logic busy_seen);
    ew_pos = -1; ew_cnt = 0; busy_seen = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      load_params = 1'b1;
      data_in     = c[CFG-1-i];
      step        = with_step && (i == 0);
      @(posedge clk);
      @(negedge clk);
      if (end_writing) begin ew_cnt++; ew_pos = i + 1; end
      if (busy) busy_seen = 1'b1;
    end
    load_params = 1'b0; data_in = 1'b0; step = 1'b0;
  endtask

  task automatic do_step(input logic [N_IN-1:0] s, output int lat, output logic busy_seen);
    step = 1'b1; spike_in = s;
    @(posedge clk);
    @(negedge clk);
    step = 1'b0; spike_in = N_IN'($urandom);
    busy_seen = busy;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_done) begin lat = n; break; end
    end
    model_step(s);
  endtask

  task automatic load_model();
    int p, c; logic b;
    shift_bits(pack_cfg(), CFG, 1'b0, p, c, b);
  endtask

  task automatic test_reset();
    logic seen;
    apply_reset();
    n_cmp++;
    if ({busy, out_spikes, step_done, end_writing, data_written} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0",
               {busy, out_spikes, step_done, end_writing, data_written});
    end
    rst_n = 1'b1;
    @(negedge clk);
    step = 1'b1; spike_in = '1;
    @(negedge clk);
    step = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy || step_done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL step_without_config: busy/step_done seen %b expected 0", seen);
    end
  endtask

  task automatic test_load();
    int p, c; logic b;
    apply_reset(); rst_n = 1'b1;
    model_random_cfg();
    shift_bits(pack_cfg(), CFG, 1'b0, p, c, b);
    n_cmp++;
    if (p != CFG || c != 1) begin
      n_bad++; $display("FAIL end_writing_pos: got bit %0d count %0d expected bit %0d count 1", p, c, CFG);
    end
    n_cmp++;
    if (data_written !== 1'b1) begin
      n_bad++; $display("FAIL data_written_full: got %b expected 1", data_written);
    end
    shift_bits(pack_cfg(), 30, 1'b0, p, c, b);
    @(negedge clk);
    n_cmp++;
    if (c != 0 || data_written !== 1'b0) begin
      n_bad++; $display("FAIL abort_load: end_writing count %0d data_written %b expected 0 and 0", c, data_written);
    end
  endtask

  task automatic run_pattern(input string name, input int nsteps, input logic [N_IN-1:0] s,
                             input logic [5:0] exp0);
    int lat; logic bs;
    for (int i = 0; i < nsteps; i++) begin
      do_step(s, lat, bs);
      n_cmp++;
      if (lat != LAT || bs !== 1'b1) begin
        n_bad++; $display("FAIL %s_latency step %0d: got %0d busy %b expected %0d busy 1", name, i + 1, lat, bs, LAT);
      end
      n_cmp++;
      if (out_spikes !== mout || out_spikes[0] !== exp0[i]) begin
        n_bad++; $display("FAIL %s_spikes step %0d: got %b expected %b (neuron0 %b)", name, i + 1, out_spikes, mout, exp0[i]);
      end
    end
  endtask

  task automatic test_integrate();
    apply_reset(); rst_n = 1'b1;
    model_clear_cfg(); mw[0][0] = 1; mthr = 3;
    load_model();
    run_pattern("integrate", 5, 3'b001, 6'b000100);
  endtask

  task automatic test_leak_and_saturate();
    int lat, first; logic bs;
    apply_reset(); rst_n = 1'b1;
    model_clear_cfg(); mw[0][0] = 1; mthr = 3; mleak = 1;
    load_model();
    run_pattern("leak", 5, 3'b001, 6'b000000);
    model_clear_cfg(); mw[0][0] = 1; mw[0][1] = 1; mw[0][2] = 1; mthr = 255;
    load_model();
    first = -1;
    for (int i = 1; i <= 88; i++) begin
      do_step(3'b111, lat, bs);
      n_cmp++;
      if (out_spikes !== mout || lat != LAT) begin
        n_bad++; $display("FAIL thr255_step %0d: got %b lat %0d expected %b lat %0d", i, out_spikes, lat, mout, LAT);
      end
      if (out_spikes[0] && first < 0) first = i;
    end
    n_cmp++;
    if (first != 85) begin
      n_bad++; $display("FAIL thr255_first_spike: got step %0d expected 85", first);
    end
  endtask

  task automatic test_refractory();
    apply_reset(); rst_n = 1'b1;
    model_clear_cfg(); mw[0][0] = 1; mthr = 1; mrefr = 2;
    load_model();
    run_pattern("refractory", 6, 3'b001, 6'b001001);
  endtask

  task automatic test_recurrence();
    int lat; logic bs; logic prev0;
    apply_reset(); rst_n = 1'b1;
    model_clear_cfg(); mw[0][0] = 1; mw[1][3] = 1; mthr = 1;
    load_model();
    prev0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_step(3'b001, lat, bs);
      n_cmp++;
      if (out_spikes !== mout || out_spikes[1] !== prev0) begin
        n_bad++; $display("FAIL recurrence step %0d: got %b expected %b (neuron1 %b)", i + 1, out_spikes, mout, prev0);
      end
      prev0 = out_spikes[0];
    end
  endtask

  task automatic test_busy_gating();
    int pulses, first, lat; logic bs;
    step = 1'b1; spike_in = 3'b001;
    @(posedge clk);
    @(negedge clk);
    model_step(3'b001);
    pulses = 0; first = -1;
    for (int n = 1; n <= 60; n++) begin
      load_params = (n <= 10);
      step        = (n <= 10);
      data_in     = 1'(($urandom));
      @(posedge clk);
      @(negedge clk);
      if (step_done) begin pulses++; if (first < 0) first = n; end
    end
    load_params = 1'b0; step = 1'b0;
    n_cmp++;
    if (pulses != 1 || first != LAT) begin
      n_bad++; $display("FAIL busy_step_ignored: got %0d pulses first at %0d expected 1 at %0d", pulses, first, LAT);
    end
    n_cmp++;
    if (data_written !== 1'b1 || out_spikes !== mout) begin
      n_bad++; $display("FAIL busy_load_ignored: data_written %b spikes %b expected 1 and %b", data_written, out_spikes, mout);
    end
    do_step(3'b001, lat, bs);
    n_cmp++;
    if (out_spikes !== mout || lat != LAT) begin
      n_bad++; $display("FAIL config_kept_after_busy: got %b lat %0d expected %b lat %0d", out_spikes, lat, mout, LAT);
    end
  endtask

  task automatic test_simultaneous();
    int p, c, lat; logic b, bs;
    model_random_cfg();
    shift_bits(pack_cfg(), CFG, 1'b1, p, c, b);
    n_cmp++;
    if (b !== 1'b0 || p != CFG || c != 1) begin
      n_bad++; $display("FAIL load_beats_step: busy %b end bit %0d count %0d expected 0 %0d 1", b, p, c, CFG);
    end
    do_step(N_IN'($urandom), lat, bs);
    n_cmp++;
    if (out_spikes !== mout || lat != LAT) begin
      n_bad++; $display("FAIL step_after_simul: got %b lat %0d expected %b lat %0d", out_spikes, lat, mout, LAT);
    end
  endtask

  task automatic test_ena();
    int lat; logic [N_IN-1:0] s;
    s = N_IN'($urandom);
    step = 1'b1; spike_in = s;
    @(posedge clk);
    @(negedge clk);
    step = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      ena = !(n <= 5);
      @(posedge clk);
      @(negedge clk);
      if (step_done) begin lat = n; break; end
    end
    ena = 1'b1;
    model_step(s);
    n_cmp++;
    if (lat != LAT + 5 || out_spikes !== mout) begin
      n_bad++; $display("FAIL ena_hold: lat %0d spikes %b expected lat %0d spikes %b", lat, out_spikes, LAT + 5, mout);
    end
  endtask

  task automatic test_random();
    int lat; logic bs; logic [N_IN-1:0] s;
    for (int round = 0; round < 3; round++) begin
      apply_reset(); rst_n = 1'b1;
      model_random_cfg();
      load_model();
      for (int i = 0; i < 15; i++) begin
        s = N_IN'($urandom);
        do_step(s, lat, bs);
        n_cmp++;
        if (out_spikes !== mout || lat != LAT) begin
          n_bad++; $display("FAIL random r%0d step %0d: got %b lat %0d expected %b lat %0d", round, i, out_spikes, lat, mout, LAT);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_integrate();
    test_leak_and_saturate();
    test_refractory();
    test_recurrence();
    test_busy_gating();
    test_simultaneous();
    test_ena();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
